mdu: RTL and testbench
======================

Name: mdu

Overview:
- Multiply/divide unit in the E stage of the five-stage MIPS pipeline, directly downstream of the control unit.
- Consumes the decoded MDUType, the forwarded rs/rt values and the E-stage enable; owns the HI/LO registers.
- Runs multi-cycle mult/multu/div/divu operations.
- Drives MDUO for mfhi/mflo and provides start/busy so the hazard unit stalls D-stage MDU instructions.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (and madd when enabled); legal range 1..15
- DIV_CYCLES, 10, busy cycles for div/divu; legal range 1..15

Ports:
- clk  input  1  pipeline clock; all state changes on rising edge
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately
- MDUType  input  5  E-stage MDU op code from the shared constants; 31 = none
- en  input  1  E-stage instruction valid; 0 (bubble/flush) masks MDUType to none
- A  input  32  forwarded rs value
- B  input  32  forwarded rt value
- start  output  1  combinational; a mult/multu/div/divu (or madd) is accepted this cycle
- busy  output  1  registered; an operation is in flight
- MDUO  output  32  combinational; HI for mfhi, LO for mflo, else 0
- HI  output  32  current HI register (debug/trace)
- LO  output  32  current LO register (debug/trace)

Behaviour:
- Op codes: mfhi 0, mflo 1, mthi 2, mtlo 3, mult 4, multu 5, div 6, divu 7, madd 8, none 31. Any other code acts as none.
- Reset (reset=0, asynchronous):
  - HI, LO, busy, counter and temp result registers go to 0; state goes to IDLE.
  - An in-flight operation is abandoned.
- States:
  - IDLE -> BUSY when start=1.
  - BUSY -> IDLE when counter==1 at a clock edge.
- start:
  - Equals en & ~busy & (op in {mult, multu, div, divu}, plus madd when enabled).
  - start never asserts while busy=1.
- Start edge (cycle 0):
  - The full result is computed from A and B and latched into temp_hi/temp_lo.
  - The counter loads N (MULT_CYCLES or DIV_CYCLES); busy goes to 1.
- Busy period:
  - busy stays 1 for exactly N cycles (cycles 1..N).
  - The counter decrements by 1 each edge.
  - At the edge ending cycle N: HI<=temp_hi, LO<=temp_lo, busy<=0.
- Result timing: new HI/LO are visible from cycle N+1. An mfhi in cycle N+1 returns the new value.
- Arithmetic:
  - mult: signed 32x32->64; HI=[63:32], LO=[31:0].
  - multu: unsigned 32x32->64; same split.
  - div: signed; LO=quotient truncated toward zero, HI=remainder with the sign of the dividend.
  - div with A=0x80000000, B=0xFFFFFFFF: LO=0x80000000, HI=0.
  - divu: unsigned; LO=quotient, HI=remainder.
  - B==0 for div/divu: the operation still runs N busy cycles, and HI/LO remain unchanged at completion.
- mthi/mtlo:
  - When en=1 and busy=0, HI<=A (mthi) or LO<=A (mtlo) at the edge.
  - Ignored while busy=1; the hazard unit guarantees this never occurs.
- mfhi/mflo while busy=1: MDUO returns the stale HI/LO. The hazard unit must stall; the block does not.
- MDU ops while busy=1: ignored with no state change, including en=1 with mult..divu.
- MDUO is purely combinational on MDUType, HI and LO; it is not gated by en.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined:
  - op 8 (madd) is accepted like mult.
  - temp {HI,LO} = {HI,LO} + signed(A)*signed(B), modulo 2^64, using the HI/LO values at the start edge.
  - Runs MULT_CYCLES busy cycles.
- Undefined: op 8 behaves as none (no start, no state change, MDUO=0).

Decomposition:
- Shared constants file:
  - MDUType codes 0..8 and 31.
  - GRFWDSrc_MDUO.
  - Default cycle counts.
- Sub-modules: none required. The arithmetic is a combinational function evaluated at the start edge inside mdu.

Test Plan:
- Reset: reset=0 mid-div (cycle 4 of 10) -> busy=0, HI=LO=0 immediately; after release, the mflo output MDUO=0.
- mult: A=0xFFFFFFFE (-2), B=3 -> start=1 in cycle 0; busy=1 in cycles 1..5; cycle 6 HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu: A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
- Signed div:
  - A=-7, B=2 -> busy 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - Divide-by-zero with prior HI=0x11, LO=0x22 -> HI/LO unchanged after 10 cycles.
- Collision:
  - mult issued while busy (cycle 3) -> start=0, HI/LO reflect only the first op.
  - en=0 with MDUType=div -> no start.
  - mthi A=0x1234 when idle -> next cycle the mfhi output MDUO=0x1234.
- madd (MDU_MADD_EN): HI=0, LO=0xFFFFFFFF, A=1, B=1 -> after 5 cycles HI=1, LO=0. Without the macro: no start, busy stays 0.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared constants for the E-stage multiply/divide unit: op codes, forwarding
// select, default latencies, FSM state type and the arithmetic helper.
package mdu_pkg;

   localparam logic [4:0] OP_MFHI  = 5'd0;
   localparam logic [4:0] OP_MFLO  = 5'd1;
   localparam logic [4:0] OP_MTHI  = 5'd2;
   localparam logic [4:0] OP_MTLO  = 5'd3;
   localparam logic [4:0] OP_MULT  = 5'd4;
   localparam logic [4:0] OP_MULTU = 5'd5;
   localparam logic [4:0] OP_DIV   = 5'd6;
   localparam logic [4:0] OP_DIVU  = 5'd7;
   localparam logic [4:0] OP_MADD  = 5'd8;
   localparam logic [4:0] OP_NONE  = 5'd31;

   localparam logic [2:0] GRFWDSrc_MDUO = 3'd4;

   localparam int DEF_MULT_CYCLES = 5;
   localparam int DEF_DIV_CYCLES  = 10;

   typedef enum logic {S_IDLE, S_BUSY} mdu_state_t;

   // Returns the new {HI,LO}; division by zero hands back the current {HI,LO}.
   function automatic logic [63:0] mdu_calc(input logic [4:0] op,
                                            input logic [31:0] a, b, hi, lo);
      logic [63:0] sa, sb, prod_s;
      logic [31:0] ma, mb, q, r;
      sa     = {{32{a[31]}}, a};
      sb     = {{32{b[31]}}, b};
      prod_s = sa * sb;
      ma     = a[31] ? -a : a;
      mb     = b[31] ? -b : b;
      q      = '0;
      r      = '0;
      mdu_calc = {hi, lo};
      case (op)
         OP_MULT:  mdu_calc = prod_s;
         OP_MULTU: mdu_calc = {32'b0, a} * {32'b0, b};
         OP_MADD:  mdu_calc = {hi, lo} + prod_s;
         OP_DIV: begin
            // magnitude divide keeps 0x80000000 / -1 well defined
            if (b != 32'd0) begin
               q = ma / mb;
               r = ma % mb;
               if (a[31] ^ b[31]) q = -q;
               if (a[31])         r = -r;
               mdu_calc = {r, q};
            end
         end
         OP_DIVU: begin
            if (b != 32'd0) mdu_calc = {a % b, a / b};
         end
         default: ;
      endcase
   endfunction

endpackage

// File: rtl/mdu_if.sv
// E-stage MDU bus: decoded op, forwarded operands, handshake and HI/LO view.
interface mdu_if;
   logic [4:0]  MDUType;
   logic        en;
   logic [31:0] A;
   logic [31:0] B;
   logic        start;
   logic        busy;
   logic [31:0] MDUO;
   logic [31:0] HI;
   logic [31:0] LO;

   modport master (output MDUType, en, A, B, input start, busy, MDUO, HI, LO);
   modport slave  (input MDUType, en, A, B, output start, busy, MDUO, HI, LO);
endinterface

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit owning HI/LO. Optional madd (op 8) is
// enabled by defining MDU_MADD_EN.
//
// state  | meaning
// S_IDLE | no op in flight; accepts mult/multu/div/divu(/madd), mthi, mtlo
// S_BUSY | result held in temp regs; counter runs down, commit at count 1
module mdu
   import mdu_pkg::*;
#(
   parameter int MULT_CYCLES = DEF_MULT_CYCLES,
   parameter int DIV_CYCLES  = DEF_DIV_CYCLES
)(
   input logic   clk,
   input logic   reset,
   mdu_if.slave  bus
);

   localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
   localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

   mdu_state_t  state, state_nx;
   logic [3:0]  cnt, cnt_nx;
   logic [31:0] hi, hi_nx, lo, lo_nx;
   logic [31:0] thi, thi_nx, tlo, tlo_nx;
   logic [4:0]  op;
   logic        start_op;
   logic        is_div;
   logic [63:0] res;

   assign op     = bus.en ? bus.MDUType : OP_NONE;
   assign is_div = (op == OP_DIV) || (op == OP_DIVU);
   assign res    = mdu_calc(op, bus.A, bus.B, hi, lo);

   always_comb begin
      start_op = (op == OP_MULT) || (op == OP_MULTU) || is_div;
`ifdef MDU_MADD_EN
      start_op = start_op || (op == OP_MADD);
`else
      start_op = start_op;
`endif
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
         cnt   <= '0;
         hi    <= '0;
         lo    <= '0;
         thi   <= '0;
         tlo   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         hi    <= hi_nx;
         lo    <= lo_nx;
         thi   <= thi_nx;
         tlo   <= tlo_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      hi_nx    = hi;
      lo_nx    = lo;
      thi_nx   = thi;
      tlo_nx   = tlo;
      case (state)
         S_IDLE: begin
            if (start_op) begin
               state_nx = S_BUSY;
               cnt_nx   = is_div ? DIV_N : MULT_N;
               thi_nx   = res[63:32];
               tlo_nx   = res[31:0];
            end else if (op == OP_MTHI) begin
               hi_nx = bus.A;
            end else if (op == OP_MTLO) begin
               lo_nx = bus.A;
            end
         end
         S_BUSY: begin
            cnt_nx = cnt - 4'd1;
            if (cnt == 4'd1) begin
               state_nx = S_IDLE;
               hi_nx    = thi;
               lo_nx    = tlo;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   assign bus.start = (state == S_IDLE) && start_op;
   assign bus.busy  = (state == S_BUSY);
   assign bus.HI    = hi;
   assign bus.LO    = lo;
   assign bus.MDUO  = (bus.MDUType == OP_MFHI) ? hi :
                      (bus.MDUType == OP_MFLO) ? lo : 32'd0;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed vector table, hand-built corner
// sequences and randomized ops against an arithmetic reference model.
module tb_mdu;
   import mdu_pkg::*;

   localparam int NM = 5;
   localparam int ND = 10;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   mdu_if bus();
   mdu #(.MULT_CYCLES(NM), .DIV_CYCLES(ND)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;

   typedef struct {
      string       name;
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;
   vec_t vecs[7];

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [4:0] op, input logic e, input logic [31:0] a, input logic [31:0] b);
      bus.MDUType = op;
      bus.en      = e;
      bus.A       = a;
      bus.B       = b;
   endtask

   function automatic logic [63:0] ref_calc(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] hi,
                                            input logic [31:0] lo);
      longint sa, sb, q, r;
      longint unsigned ua, ub;
      logic [63:0] acc;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      acc = {hi, lo};
      case (op)
         OP_MULT:  acc = sa * sb;
         OP_MULTU: acc = ua * ub;
         OP_MADD:  acc = {hi, lo} + 64'(sa * sb);
         OP_DIV:   if (b != 0) begin q = sa / sb; r = sa % sb; acc = {r[31:0], q[31:0]}; end
         OP_DIVU:  if (b != 0) acc = {32'(ua % ub), 32'(ua / ub)};
         default:  ;
      endcase
      return acc;
   endfunction

   task automatic run_op(input string name, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int n;
      n = (op == OP_DIV || op == OP_DIVU) ? ND : NM;
      drive(op, 1'b1, a, b);
      #1;
      check({name, " start"}, 32'(bus.start), 32'd1);
      tick();
      drive(OP_NONE, 1'b0, 32'd0, 32'd0);
      for (int k = 1; k <= n; k++) begin
         #1;
         check({name, " busy"}, 32'(bus.busy), 32'd1);
         tick();
      end
      #1;
      check({name, " done"}, 32'(bus.busy), 32'd0);
      check({name, " HI"}, bus.HI, exp_hi);
      check({name, " LO"}, bus.LO, exp_lo);
      drive(OP_MFHI, 1'b1, 32'd0, 32'd0);
      #1;
      check({name, " mfhi"}, bus.MDUO, exp_hi);
      drive(OP_MFLO, 1'b1, 32'd0, 32'd0);
      #1;
      check({name, " mflo"}, bus.MDUO, exp_lo);
      drive(OP_NONE, 1'b0, 32'd0, 32'd0);
      m_hi = exp_hi;
      m_lo = exp_lo;
   endtask

   task automatic set_hilo(input logic [31:0] h, input logic [31:0] l);
      drive(OP_MTHI, 1'b1, h, 32'd0);
      tick();
      drive(OP_MTLO, 1'b1, l, 32'd0);
      tick();
      drive(OP_MFHI, 1'b0, 32'd0, 32'd0);
      #1;
      check("mthi mfhi", bus.MDUO, h);
      check("mtlo LO", bus.LO, l);
      drive(OP_NONE, 1'b0, 32'd0, 32'd0);
      m_hi = h;
      m_lo = l;
   endtask

   initial begin
      logic [4:0]  rop;
      logic [31:0] ra, rb;
      logic [63:0] exp;

      vecs[0] = '{"mult neg",  OP_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA};
      vecs[1] = '{"multu max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
      vecs[2] = '{"div -7/2",  OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[3] = '{"div ovf",   OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
      vecs[4] = '{"divu",      OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
      vecs[5] = '{"mult mix",  OP_MULT,  32'd7,        32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFD6};
      vecs[6] = '{"div 7/-2",  OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};

      drive(OP_NONE, 1'b0, 32'd0, 32'd0);
      reset = 1'b0;
      #12;
      check("reset busy", 32'(bus.busy), 32'd0);
      check("reset HI", bus.HI, 32'd0);
      check("reset LO", bus.LO, 32'd0);
      reset = 1'b1;
      tick();

      for (int i = 0; i < 7; i++)
         run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);

      // divide by zero leaves HI/LO untouched after the full busy period
      set_hilo(32'h11, 32'h22);
      run_op("div0", OP_DIV, 32'd55, 32'd0, 32'h11, 32'h22);
      run_op("divu0", OP_DIVU, 32'd55, 32'd0, 32'h11, 32'h22);

      // mthi then mfhi next cycle
      drive(OP_MTHI, 1'b1, 32'h1234, 32'd0);
      tick();
      drive(OP_MFHI, 1'b1, 32'd0, 32'd0);
      #1;
      check("mthi 1234", bus.MDUO, 32'h1234);
      m_hi = 32'h1234;
      drive(OP_NONE, 1'b0, 32'd0, 32'd0);

      // second mult during busy, mthi during busy, mfhi returns stale HI
      drive(OP_MULT, 1'b1, 32'd7, 32'd6);
      #1;
      check("coll start0", 32'(bus.start), 32'd1);
      tick();
      drive(OP_NONE, 1'b0, 32'd0, 32'd0);
      tick();
      tick();
      drive(OP_MULT, 1'b1, 32'd100, 32'd100);
      #1;
      check("coll start3", 32'(bus.start), 32'd0);
      tick();
      drive(OP_MTHI, 1'b1, 32'hDEAD, 32'd0);
      tick();
      drive(OP_MFHI, 1'b1, 32'd0, 32'd0);
      #1;
      check("coll stale", bus.MDUO, m_hi);
      drive(OP_NONE, 1'b0, 32'd0, 32'd0);
      tick();
      #1;
      check("coll busy", 32'(bus.busy), 32'd0);
      check("coll HI", bus.HI, 32'd0);
      check("coll LO", bus.LO, 32'd42);
      m_hi = 32'd0;
      m_lo = 32'd42;

      // en=0 masks div; unknown op behaves as none
      drive(OP_DIV, 1'b0, 32'd100, 32'd3);
      #1;
      check("en0 start", 32'(bus.start), 32'd0);
      tick();
      #1;
      check("en0 busy", 32'(bus.busy), 32'd0);
      drive(5'd12, 1'b1, 32'd9, 32'd9);
      #1;
      check("op12 start", 32'(bus.start), 32'd0);
      check("op12 MDUO", bus.MDUO, 32'd0);
      tick();
      #1;
      check("op12 LO", bus.LO, m_lo);

`ifdef MDU_MADD_EN
      set_hilo(32'd0, 32'hFFFFFFFF);
      run_op("madd", OP_MADD, 32'd1, 32'd1, 32'd1, 32'd0);
`else
      drive(OP_MADD, 1'b1, 32'd1, 32'd1);
      #1;
      check("madd off start", 32'(bus.start), 32'd0);
      check("madd off MDUO", bus.MDUO, 32'd0);
      tick();
      #1;
      check("madd off busy", 32'(bus.busy), 32'd0);
      check("madd off LO", bus.LO, m_lo);
      drive(OP_NONE, 1'b0, 32'd0, 32'd0);
`endif

      for (int i = 0; i < 30; i++) begin
         case ($urandom_range(0, 4))
            0: rop = OP_MULT;
            1: rop = OP_MULTU;
            2: rop = OP_DIV;
            3: rop = OP_DIVU;
`ifdef MDU_MADD_EN
            default: rop = OP_MADD;
`else
            default: rop = OP_MULT;
`endif
         endcase
         ra = $urandom;
         if ($urandom_range(0, 7) == 0)      rb = 32'd0;
         else if ($urandom_range(0, 1) == 0) rb = $urandom_range(1, 20);
         else                                rb = $urandom;
         exp = ref_calc(rop, ra, rb, m_hi, m_lo);
         run_op("rand", rop, ra, rb, exp[63:32], exp[31:0]);
      end

      // asynchronous reset in cycle 4 of a divide
      set_hilo(32'hAAAA, 32'h5555);
      drive(OP_DIV, 1'b1, 32'd1000, 32'd7);
      tick();
      drive(OP_NONE, 1'b0, 32'd0, 32'd0);
      tick();
      tick();
      tick();
      #1;
      check("pre-reset busy", 32'(bus.busy), 32'd1);
      reset = 1'b0;
      #1;
      check("rst busy", 32'(bus.busy), 32'd0);
      check("rst HI", bus.HI, 32'd0);
      check("rst LO", bus.LO, 32'd0);
      tick();
      reset = 1'b1;
      drive(OP_MFLO, 1'b1, 32'd0, 32'd0);
      #1;
      check("rst mflo", bus.MDUO, 32'd0);
      drive(OP_NONE, 1'b0, 32'd0, 32'd0);
      repeat (ND + 2) tick();
      #1;
      check("abandon busy", 32'(bus.busy), 32'd0);
      check("abandon LO", bus.LO, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
